// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Default 640x480@60 raster timing shared by the VGA timing generator and
//   its axis counters. Totals and sync window bounds are derived here so the
//   individual porch/sync widths remain the only numbers edited by hand.
//   No ports (package).
package vga_timing_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;  // 800
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;  // 525

  // Sync windows are half-open: [start, end).
  localparam int VGA_HS_START = VGA_H_VISIBLE + VGA_H_FRONT;   // 656
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;     // 752
  localparam int VGA_VS_START = VGA_V_VISIBLE + VGA_V_FRONT;   // 490
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;     // 492

  // Position counter width; must hold VGA_H_TOTAL-1 and VGA_V_TOTAL-1.
  localparam int VGA_CNT_W = 10;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   Wrapping position counter for one raster axis. Counts 0..LIMIT-1 on each
//   cycle with inc_i high and wraps to 0. Reset parks the counter at LIMIT-1 so
//   the first increment after reset lands on 0.
// Ports
//   clk_i       in   1  clock
//   rst_ni      in   1  asynchronous active-low reset
//   inc_i       in   1  advance by one this cycle
//   cnt_o       out  W  current (registered) count
//   cnt_next_o  out  W  value cnt_o will take after this edge
//   wrap_o      out  1  this cycle's increment wraps LIMIT-1 -> 0
module vga_axis_counter #(
  parameter int LIMIT = 800,
  parameter int W     = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_next_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         wrap;

  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (inc_i) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= LAST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;
  assign wrap_o     = wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing source for one VGA port. Produces the DrawX/DrawY position,
//   the visible-region flag (blank, 1 = visible), active-low HSYNC/VSYNC,
//   one-cycle line/frame start strobes and an 8-bit frame counter.
//   Every output is a register. The decoded flags are computed from the
//   counters' next-position values so they change on the same edge as
//   DrawX/DrawY and always describe the position currently shown.
// Ports
//   vga_clk      in   1      pixel-domain clock
//   reset_n      in   1      asynchronous active-low reset
//   pix_en       in   1      advance enable (tie 1 when vga_clk is the pixel clock)
//   DrawX        out  CNT_W  horizontal position 0..H_TOTAL-1
//   DrawY        out  CNT_W  vertical position 0..V_TOTAL-1
//   blank        out  1      1 while in the visible region
//   hs           out  1      HSYNC, active low
//   vs           out  1      VSYNC, active low
//   line_start   out  1      strobe on the cycle DrawX becomes 0
//   frame_start  out  1      strobe on the cycle (0,0) is entered
//   frame_count  out  8      completed frames, modulo 256
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int CNT_W     = VGA_CNT_W
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] DrawX,
  output logic [CNT_W-1:0] DrawY,
  output logic             blank,
  output logic             hs,
  output logic             vs,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] h_cnt, h_next;
  logic [CNT_W-1:0] v_cnt, v_next;
  logic             h_wrap, v_wrap;
  logic             v_inc;

  assign v_inc = pix_en & h_wrap;

  vga_axis_counter #(.LIMIT(H_TOTAL), .W(CNT_W)) u_h_cnt (
    .clk_i      (vga_clk),
    .rst_ni     (reset_n),
    .inc_i      (pix_en),
    .cnt_o      (h_cnt),
    .cnt_next_o (h_next),
    .wrap_o     (h_wrap)
  );

  vga_axis_counter #(.LIMIT(V_TOTAL), .W(CNT_W)) u_v_cnt (
    .clk_i      (vga_clk),
    .rst_ni     (reset_n),
    .inc_i      (v_inc),
    .cnt_o      (v_cnt),
    .cnt_next_o (v_next),
    .wrap_o     (v_wrap)
  );

  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;
  // Set by the first advance after reset. The wrap out of the parked reset
  // position (H_TOTAL-1, V_TOTAL-1) is not a completed frame, so it must not
  // bump frame_count.
  logic       started_q, started_d;

  always_comb begin
    blank_d       = (h_next < H_VIS_END) && (v_next < V_VIS_END);
    hs_d          = !((h_next >= HS_START) && (h_next < HS_END));
    vs_d          = !((v_next >= VS_START) && (v_next < VS_END));
    // Wrap flags already include pix_en, so hold cycles never re-fire strobes.
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && v_wrap;
    started_d     = started_q | pix_en;
    frame_count_d = frame_count_q;
    if (frame_start_d && started_q) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
      started_q     <= 1'b0;
    end else begin
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      started_q     <= started_d;
    end
  end

  assign DrawX       = h_cnt;
  assign DrawY       = v_cnt;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Drives two instances from one stimulus stream: one with the default
//   640x480 timing (line-level checks) and one with a tiny raster
//   (15x8 total) so whole frames and the 256-frame wrap fit in a short run.
//   Expected outputs come from an arithmetic model: after n advances the
//   position is linear index n-1 in the raster.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    bit   pe;
    obs_t exp;
  } vec_t;

  // Tiny raster: H 8+2+3+2 = 15, V 4+1+2+1 = 8, 120 cycles per frame.
  localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VV = 4, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_FRAME = 120;

  logic       vga_clk;
  logic       reset_n;
  logic       pix_en;

  logic [9:0] d_x, d_y, s_x, s_y;
  logic       d_blank, d_hs, d_vs, d_ls, d_fs;
  logic       s_blank, s_hs, s_vs, s_ls, s_fs;
  logic [7:0] d_fc, s_fc;

  obs_t d_act, s_act;
  assign d_act = {d_x, d_y, d_blank, d_hs, d_vs, d_ls, d_fs, d_fc};
  assign s_act = {s_x, s_y, s_blank, s_hs, s_vs, s_ls, s_fs, s_fc};

  vga_timing_gen u_dflt (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .pix_en      (pix_en),
    .DrawX       (d_x),
    .DrawY       (d_y),
    .blank       (d_blank),
    .hs          (d_hs),
    .vs          (d_vs),
    .line_start  (d_ls),
    .frame_start (d_fs),
    .frame_count (d_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .CNT_W(10)
  ) u_small (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .pix_en      (pix_en),
    .DrawX       (s_x),
    .DrawY       (s_y),
    .blank       (s_blank),
    .hs          (s_hs),
    .vs          (s_vs),
    .line_start  (s_ls),
    .frame_start (s_fs),
    .frame_count (s_fc)
  );

  // ---------------- clock ----------------
  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int n_adv    = 0;    // pix_en edges since reset release
  bit last_adv = 1'b0; // did the most recent edge advance

  function automatic obs_t model(input int hv, hf, hsy, hb, vv, vf, vsy, vb,
                                 input int n, input bit adv);
    obs_t o;
    int ht, vt, idx, x, y, frame;
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    if (n == 0) begin
      o = {10'(ht - 1), 10'(vt - 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    end else begin
      idx   = (n - 1) % (ht * vt);
      frame = (n - 1) / (ht * vt);
      x     = idx % ht;
      y     = idx / ht;
      o.x     = 10'(x);
      o.y     = 10'(y);
      o.blank = (x < hv) && (y < vv);
      o.hs    = !((x >= hv + hf) && (x < hv + hf + hsy));
      o.vs    = !((y >= vv + vf) && (y < vv + vf + vsy));
      o.ls    = adv && (x == 0);
      o.fs    = adv && (x == 0) && (y == 0);
      o.fc    = 8'(frame % 256);
    end
    return o;
  endfunction

  function automatic obs_t mk(input int x, y, input bit b, h, v, l, f, input int fc);
    return {10'(x), 10'(y), b, h, v, l, f, 8'(fc)};
  endfunction

  task automatic cmp(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
               name, act.x, act.y, act.blank, act.hs, act.vs, act.ls, act.fs, act.fc,
               exp.x, exp.y, exp.blank, exp.hs, exp.vs, exp.ls, exp.fs, exp.fc);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    cmp({tag, "_dflt"}, d_act, model(640, 16, 96, 48, 480, 10, 2, 33, n_adv, last_adv));
    cmp({tag, "_small"}, s_act, model(S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB,
                                      n_adv, last_adv));
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; inputs change away from the active edge.
  task automatic step(input bit pe);
    pix_en = pe;
    @(posedge vga_clk);
    if (reset_n) begin
      if (pe) n_adv++;
      last_adv = pe;
    end
    #1;
    check_model("step");
  endtask

  // Asserts reset between edges and checks that the outputs change without
  // waiting for a clock, then releases just after an edge.
  task automatic do_reset();
    reset_n  = 1'b0;
    pix_en   = 1'b0;
    n_adv    = 0;
    last_adv = 1'b0;
    #2;
    check_model("async_reset");
    @(posedge vga_clk);
    @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    #1;
    check_model("reset_release");
  endtask

  // ---------------- test ----------------
  vec_t vecs[19];
  int   hs_low, blank_hi, hs_fall_x, hs_rise_x, blank_fall_x;
  bit   prev_hs, prev_blank;
  int   vs_low, fs_first, fs_second, fc_at_second, xbad;

  initial begin
    reset_n = 1'b1;
    pix_en  = 1'b0;

    // Tiny-raster vectors from reset: hs low at x 10..12, blank falls at x 8.
    vecs[0]  = '{1'b1, mk(0, 0, 1, 1, 1, 1, 1, 0)};
    vecs[1]  = '{1'b0, mk(0, 0, 1, 1, 1, 0, 0, 0)};
    vecs[2]  = '{1'b0, mk(0, 0, 1, 1, 1, 0, 0, 0)};
    vecs[3]  = '{1'b1, mk(1, 0, 1, 1, 1, 0, 0, 0)};
    for (int i = 4; i <= 9; i++) vecs[i] = '{1'b1, mk(i - 2, 0, 1, 1, 1, 0, 0, 0)};
    vecs[10] = '{1'b1, mk(8, 0, 0, 1, 1, 0, 0, 0)};
    vecs[11] = '{1'b1, mk(9, 0, 0, 1, 1, 0, 0, 0)};
    vecs[12] = '{1'b1, mk(10, 0, 0, 0, 1, 0, 0, 0)};
    vecs[13] = '{1'b0, mk(10, 0, 0, 0, 1, 0, 0, 0)};
    vecs[14] = '{1'b1, mk(11, 0, 0, 0, 1, 0, 0, 0)};
    vecs[15] = '{1'b1, mk(12, 0, 0, 0, 1, 0, 0, 0)};
    vecs[16] = '{1'b1, mk(13, 0, 0, 1, 1, 0, 0, 0)};
    vecs[17] = '{1'b1, mk(14, 0, 0, 1, 1, 0, 0, 0)};
    vecs[18] = '{1'b1, mk(0, 1, 1, 1, 1, 1, 0, 0)};

    #3;
    do_reset();
    cmp("reset_dflt_const", d_act, mk(799, 524, 0, 1, 1, 0, 0, 0));
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].pe);
      cmp($sformatf("vec%0d", i), s_act, vecs[i].exp);
    end

    // Randomised enable with a mid-run asynchronous reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(negedge vga_clk);
        #2;
        do_reset();
      end
      step($urandom_range(0, 3) != 0);
    end

    // Default-timing line scan.
    do_reset();
    hs_low = 0; blank_hi = 0; hs_fall_x = -1; hs_rise_x = -1; blank_fall_x = -1;
    prev_hs = d_hs; prev_blank = d_blank;
    for (int i = 0; i < 800; i++) begin
      step(1'b1);
      if (!d_hs) hs_low++;
      if (d_blank) blank_hi++;
      if (prev_hs && !d_hs && hs_fall_x < 0) hs_fall_x = int'(d_x);
      if (!prev_hs && d_hs && hs_rise_x < 0) hs_rise_x = int'(d_x);
      if (prev_blank && !d_blank && blank_fall_x < 0) blank_fall_x = int'(d_x);
      prev_hs = d_hs; prev_blank = d_blank;
    end
    cmp_int("hs_low_cycles", hs_low, 96);
    cmp_int("blank_vis_cycles", blank_hi, 640);
    cmp_int("hs_fall_x", hs_fall_x, 656);
    cmp_int("hs_rise_x", hs_rise_x, 752);
    cmp_int("blank_fall_x", blank_fall_x, 640);
    step(1'b1);
    cmp_int("blank_back_line1", int'(d_blank), 1);

    // Tiny-raster frame scan, then run on to 256 completed frames.
    do_reset();
    vs_low = 0; fs_first = -1; fs_second = -1; fc_at_second = -1; xbad = 0;
    for (int i = 1; i <= 2 * S_FRAME + 1; i++) begin
      step(1'b1);
      if (i <= S_FRAME && !s_vs) vs_low++;
      if (i <= S_FRAME && ($isunknown(s_act) || $isunknown(d_act))) xbad++;
      if (s_fs) begin
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) begin
          fs_second    = i;
          fc_at_second = int'(s_fc);
        end
      end
    end
    cmp_int("vs_low_cycles", vs_low, S_VS * 15);
    cmp_int("frame_period", fs_second - fs_first, S_FRAME);
    cmp_int("fc_second_frame", fc_at_second, 1);
    cmp_int("no_x_frame", xbad, 0);
    while (n_adv < 256 * S_FRAME + 1) step(1'b1);
    cmp("fc_wrap_256", s_act, mk(0, 0, 1, 1, 1, 1, 1, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
